// File: rtl/lcd_text_pkg.sv
// Shared text-grid types, ASCII control codes and writer FSM encoding for the LCD text terminal.
package lcd_text_pkg;

    localparam int COL_W  = 7;
    localparam int ROW_W  = 6;
    localparam int CHAR_W = 7;

    typedef logic [COL_W-1:0]  col_t;
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t CH_SPACE = 7'h20;
    localparam char_t CH_LF    = 7'h0A;
    localparam char_t CH_CR    = 7'h0D;
    localparam char_t CH_BS    = 7'h08;
    localparam char_t CH_FF    = 7'h0C;
    localparam char_t CH_BLOCK = 7'h7F;

    localparam logic [1:0] ST_CLEAR_ALL  = 2'd0;
    localparam logic [1:0] ST_IDLE       = 2'd1;
    localparam logic [1:0] ST_CLEAR_LINE = 2'd2;

    function automatic logic is_printable(input char_t c);
        return (c >= CH_SPACE) && (c <= 7'h7E);
    endfunction

endpackage

// File: rtl/lcd_text_terminal_if.sv
// Byte-stream writer port plus text-grid reader port of the LCD text terminal.
interface lcd_text_terminal_if;
    import lcd_text_pkg::*;

    logic  in_valid;
    char_t in_char;
    logic  in_ready;
    col_t  column;
    row_t  row;
    char_t character;
    col_t  cursor_column;
    row_t  cursor_row;

    modport master (
        output in_valid, in_char, column, row,
        input  in_ready, character, cursor_column, cursor_row
    );

    modport slave (
        input  in_valid, in_char, column, row,
        output in_ready, character, cursor_column, cursor_row
    );

endinterface

// File: rtl/lcd_text_ram.sv
// Simple dual-port character store: one write port, one registered read port (read-before-write).
module lcd_text_ram #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 7,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lcd_text_terminal.sv
// Character-cell frame store with terminal-style writer (cursor, wrap, scroll, clear) and grid reader.
// Optional cursor blink is built in when LCD_TEXT_TERMINAL_CURSOR_BLINK_EN is defined.
module lcd_text_terminal
    import lcd_text_pkg::*;
#(
    parameter int COLUMNS    = 40,
    parameter int ROWS       = 16,
    parameter int BLINK_LOG2 = 24
) (
    input logic                clock,
    input logic                reset,
    lcd_text_terminal_if.slave term
);

    localparam int CELLS = COLUMNS * ROWS;
    localparam int AW    = $clog2(CELLS);

    logic [1:0]    state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] line_base;
    row_t          top;
    row_t          cur_row;
    col_t          cur_col;
    logic          ready;

    logic          accept;
    logic          printable;
    logic          line_feed;
    logic          we;
    logic [AW-1:0] waddr;
    char_t         wdata;

    logic          out_of_range;
    logic          cursor_hit;
    logic          blink_phase;
    logic [AW-1:0] raddr;
    char_t         ram_q;
    logic          oor_p1;
    logic          block_p1;

    function automatic row_t wrap_row(input row_t r, input row_t t);
        int s;
        s = int'(r) + int'(t);
        if (s >= ROWS) s = s - ROWS;
        return row_t'(s);
    endfunction

    function automatic logic [AW-1:0] cell_addr(input row_t prow, input col_t col);
        return AW'(int'(prow) * COLUMNS + int'(col));
    endfunction

    always_comb begin
        accept    = (state == ST_IDLE) && ready && term.in_valid;
        printable = is_printable(term.in_char);
        line_feed = 1'b0;
        if (accept) begin
            if (printable) line_feed = (cur_col == col_t'(COLUMNS - 1));
            else           line_feed = (term.in_char == CH_LF);
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = cnt;
        wdata = CH_SPACE;
        case (state)
            ST_CLEAR_ALL:  we = 1'b1;
            ST_CLEAR_LINE: begin
                we    = 1'b1;
                waddr = line_base + cnt;
            end
            default: begin
                if (accept && printable) begin
                    we    = 1'b1;
                    waddr = cell_addr(wrap_row(cur_row, top), cur_col);
                    wdata = term.in_char;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_CLEAR_ALL;
            cnt       <= '0;
            line_base <= '0;
            top       <= '0;
            cur_col   <= '0;
            cur_row   <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR_ALL: begin
                    if (cnt == AW'(CELLS - 1)) begin
                        state   <= ST_IDLE;
                        ready   <= 1'b1;
                        cnt     <= '0;
                        top     <= '0;
                        cur_col <= '0;
                        cur_row <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                ST_CLEAR_LINE: begin
                    if (cnt == AW'(COLUMNS - 1)) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            cur_col <= line_feed ? '0 : cur_col + 7'd1;
                        end else begin
                            case (term.in_char)
                                CH_LF, CH_CR: cur_col <= '0;
                                CH_BS: if (cur_col != '0) cur_col <= cur_col - 7'd1;
                                CH_FF: begin
                                    state <= ST_CLEAR_ALL;
                                    ready <= 1'b0;
                                    cnt   <= '0;
                                end
                                default: ;
                            endcase
                        end
                        // Bottom-line feed: the old top physical row becomes the new bottom line
                        if (line_feed) begin
                            if (cur_row != row_t'(ROWS - 1)) begin
                                cur_row <= cur_row + 6'd1;
                            end else begin
                                top       <= (top == row_t'(ROWS - 1)) ? '0 : top + 6'd1;
                                line_base <= cell_addr(top, 7'd0);
                                state     <= ST_CLEAR_LINE;
                                ready     <= 1'b0;
                                cnt       <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_CLEAR_ALL;
                    ready <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    lcd_text_ram #(
        .DEPTH  (CELLS),
        .DATA_W (CHAR_W)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (ram_q)
    );

    always_comb begin
        out_of_range = (term.column >= col_t'(COLUMNS)) || (term.row >= row_t'(ROWS));
        raddr        = out_of_range ? '0 : cell_addr(wrap_row(term.row, top), term.column);
        cursor_hit   = (term.column == cur_col) && (term.row == cur_row) &&
                       (cur_col < col_t'(COLUMNS));
    end

`ifdef LCD_TEXT_TERMINAL_CURSOR_BLINK_EN
    logic [BLINK_LOG2:0] blink_cnt;

    always_ff @(posedge clock) begin
        if (reset) blink_cnt <= '0;
        else       blink_cnt <= blink_cnt + 1'b1;
    end

    assign blink_phase = blink_cnt[BLINK_LOG2];
`else
    // Always low; the blink index only matters when the feature is built in
    assign blink_phase = (BLINK_LOG2 < 0);
`endif

    // Read stage p1: range and cursor decode registered alongside the RAM output
    always_ff @(posedge clock) begin
        if (reset) begin
            oor_p1   <= 1'b1;
            block_p1 <= 1'b0;
        end else begin
            oor_p1   <= out_of_range;
            block_p1 <= blink_phase && cursor_hit;
        end
    end

    assign term.character     = oor_p1 ? CH_SPACE : (block_p1 ? CH_BLOCK : ram_q);
    assign term.in_ready      = ready;
    assign term.cursor_column = cur_col;
    assign term.cursor_row    = cur_row;

endmodule

// File: tb/tb_lcd_text_terminal.sv
// Self-checking bench for lcd_text_terminal: directed tables, hand sequences and random bytes vs a screen model.
module tb_lcd_text_terminal;
    import lcd_text_pkg::*;

    localparam int COLUMNS    = 40;
    localparam int ROWS       = 16;
    localparam int BLINK_LOG2 = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    lcd_text_terminal_if tif();

    lcd_text_terminal #(
        .COLUMNS    (COLUMNS),
        .ROWS       (ROWS),
        .BLINK_LOG2 (BLINK_LOG2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .term  (tif)
    );

    always #10 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Logical screen model: row 0 is always the top line; scrolling shifts rows up
    logic [6:0] scr [ROWS][COLUMNS];
    int mcc;
    int mcr;

    typedef struct {
        logic [6:0] col;
        logic [5:0] row;
        logic [6:0] exp;
    } read_vec_t;

    typedef struct {
        logic [6:0] ch;
        int         exp_col;
        int         exp_row;
    } ctrl_vec_t;

    function automatic void m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLUMNS; c++) scr[r][c] = 7'h20;
        mcc = 0;
        mcr = 0;
    endfunction

    function automatic void m_lf();
        if (mcr < ROWS - 1) begin
            mcr++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r + 1];
            for (int c = 0; c < COLUMNS; c++) scr[ROWS - 1][c] = 7'h20;
        end
    endfunction

    function automatic void m_byte(input logic [6:0] ch);
        if (ch >= 7'h20 && ch <= 7'h7E) begin
            scr[mcr][mcc] = ch;
            mcc++;
            if (mcc == COLUMNS) begin
                mcc = 0;
                m_lf();
            end
        end else if (ch == 7'h0A) begin
            mcc = 0;
            m_lf();
        end else if (ch == 7'h0D) begin
            mcc = 0;
        end else if (ch == 7'h08) begin
            if (mcc > 0) mcc--;
        end else if (ch == 7'h0C) begin
            m_clear();
        end
    endfunction

    function automatic logic cell_ok(input int c, input int r, input logic [6:0] got,
                                     input logic [6:0] exp);
        logic ok;
        ok = (got === exp);
`ifdef LCD_TEXT_TERMINAL_CURSOR_BLINK_EN
        if (got === 7'h7F && c == mcc && r == mcr) ok = 1'b1;
`endif
        return ok;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_char(input string name, input int c, input int r,
                              input logic [6:0] got, input logic [6:0] exp);
        logic [6:0] e;
        e = cell_ok(c, r, got, exp) ? got : exp;
        check(name, {25'd0, got}, {25'd0, e});
    endtask

    task automatic check_cursor(input string name);
        check({name, "_col"}, {25'd0, tif.cursor_column}, mcc);
        check({name, "_row"}, {26'd0, tif.cursor_row}, mcr);
    endtask

    task automatic read_char(input int c, input int r, output logic [6:0] ch);
        tif.column = 7'(c);
        tif.row    = 6'(r);
        @(negedge clock);
        ch = tif.character;
    endtask

    task automatic check_screen(input string name);
        int bad;
        int fc;
        int fr;
        logic [6:0] got;
        logic [6:0] fg;
        bad = 0;
        fc  = 0;
        fr  = 0;
        fg  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLUMNS; c++) begin
                read_char(c, r, got);
                if (!cell_ok(c, r, got, scr[r][c])) begin
                    if (bad == 0) begin
                        fc = c;
                        fr = r;
                        fg = got;
                    end
                    bad++;
                end
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s: %0d cells differ, first (%0d,%0d) got 0x%0h expected 0x%0h",
                     name, bad, fc, fr, fg, scr[fr][fc]);
        end
    endtask

    task automatic busy_count(output int n);
        n = 0;
        while (tif.in_ready !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic send_byte(input logic [6:0] ch);
        int n;
        busy_count(n);
        if (n >= 5000) check("ready_timeout", {31'd0, tif.in_ready}, 32'd1);
        tif.in_valid = 1'b1;
        tif.in_char  = ch;
        @(negedge clock);
        tif.in_valid = 1'b0;
        m_byte(ch);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] b;
            b = s[i];
            send_byte(b[6:0]);
        end
    endtask

    initial begin
        #1_900_000;
        $display("FAIL watchdog: run still active at time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        read_vec_t  rv [10];
        ctrl_vec_t  cv [12];
        int         n;
        logic [6:0] got;
        logic [6:0] ch;
        int         k;
        int         blk;
        int         other;

        rv[0] = '{7'd0,   6'd0,  7'h41};
        rv[1] = '{7'd1,   6'd0,  7'h42};
        rv[2] = '{7'd0,   6'd0,  7'h41};
        rv[3] = '{7'd2,   6'd0,  7'h20};
        rv[4] = '{7'd1,   6'd0,  7'h42};
        rv[5] = '{7'd50,  6'd3,  7'h20};
        rv[6] = '{7'd0,   6'd0,  7'h41};
        rv[7] = '{7'd39,  6'd15, 7'h20};
        rv[8] = '{7'd0,   6'd16, 7'h20};
        rv[9] = '{7'd127, 6'd63, 7'h20};

        cv[0]  = '{7'h08, 0, 0};
        cv[1]  = '{7'h61, 1, 0};
        cv[2]  = '{7'h62, 2, 0};
        cv[3]  = '{7'h0D, 0, 0};
        cv[4]  = '{7'h5A, 1, 0};
        cv[5]  = '{7'h08, 0, 0};
        cv[6]  = '{7'h08, 0, 0};
        cv[7]  = '{7'h01, 0, 0};
        cv[8]  = '{7'h7F, 0, 0};
        cv[9]  = '{7'h0A, 0, 1};
        cv[10] = '{7'h71, 1, 1};
        cv[11] = '{7'h1B, 1, 1};

        tif.in_valid = 1'b0;
        tif.in_char  = '0;
        tif.column   = '0;
        tif.row      = '0;
        m_clear();

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_character", {25'd0, tif.character}, 32'h20);
        check("reset_in_ready", {31'd0, tif.in_ready}, 32'd0);
        check_cursor("reset_cursor");
        reset = 1'b0;
        busy_count(n);
        check("init_busy_cycles", n, 640);
        check_screen("init_blank");

        // "AB" then table of reads, alternating addresses to expose read latency
        send_str("AB");
        for (int i = 0; i < 10; i++) begin
            read_char(int'(rv[i].col), int'(rv[i].row), got);
            check_char($sformatf("ab_read_%0d", i), int'(rv[i].col), int'(rv[i].row), got, rv[i].exp);
        end
        check("ab_cursor_col", {25'd0, tif.cursor_column}, 32'd2);
        check("ab_cursor_row", {26'd0, tif.cursor_row}, 32'd0);

        // Write and read the same cell in one cycle: old data first, new data next
        tif.column   = 7'd2;
        tif.row      = 6'd0;
        tif.in_valid = 1'b1;
        tif.in_char  = 7'h43;
        @(negedge clock);
        tif.in_valid = 1'b0;
        check_char("rw_same_cell_old", 2, 0, tif.character, 7'h20);
        m_byte(7'h43);
        @(negedge clock);
        check_char("rw_same_cell_new", 2, 0, tif.character, 7'h43);

        // Form feed
        send_byte(7'h0C);
        busy_count(n);
        check("ff_busy_cycles", n, 640);
        check_screen("ff_blank");
        check_cursor("ff_cursor");

        // Line wrap
        for (int i = 0; i < COLUMNS; i++) send_byte(7'h78);
        send_byte(7'h79);
        read_char(0, 1, got);
        check_char("wrap_0_1", 0, 1, got, 7'h79);
        check("wrap_cursor_col", {25'd0, tif.cursor_column}, 32'd1);
        check("wrap_cursor_row", {26'd0, tif.cursor_row}, 32'd1);
        check_screen("wrap_screen");

        // Fill every row then scroll on the final line feed
        send_byte(7'h0C);
        busy_count(n);
        for (int r = 0; r < ROWS; r++) begin
            ch = 7'h61 + 7'(r);
            send_byte(ch);
            send_byte(ch);
            send_byte(7'h0A);
        end
        busy_count(n);
        check("scroll_busy_cycles", n, 40);
        read_char(0, 0, got);
        check_char("scroll_row0", 0, 0, got, 7'h62);
        read_char(0, 14, got);
        check_char("scroll_row14", 0, 14, got, 7'h70);
        read_char(0, 15, got);
        check_char("scroll_row15", 0, 15, got, 7'h20);
        check("scroll_cursor_col", {25'd0, tif.cursor_column}, 32'd0);
        check("scroll_cursor_row", {26'd0, tif.cursor_row}, 32'd15);
        check_screen("scroll_screen");

        // Reset in the middle of a line clear
        send_byte(7'h0A);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_clear();
        busy_count(n);
        check("reset_mid_clear_busy", n, 640);
        check_cursor("reset_mid_clear_cursor");
        check_screen("reset_mid_clear_blank");

        // Control-code table
        for (int i = 0; i < 12; i++) begin
            send_byte(cv[i].ch);
            busy_count(n);
            check($sformatf("ctrl_%0d_col", i), {25'd0, tif.cursor_column}, cv[i].exp_col);
            check($sformatf("ctrl_%0d_row", i), {26'd0, tif.cursor_row}, cv[i].exp_row);
        end
        read_char(0, 0, got);
        check_char("ctrl_read_0_0", 0, 0, got, 7'h5A);
        read_char(1, 0, got);
        check_char("ctrl_read_1_0", 1, 0, got, 7'h62);
        read_char(0, 1, got);
        check_char("ctrl_read_0_1", 0, 1, got, 7'h71);
        send_byte(7'h0C);
        busy_count(n);
        check("ctrl_ff_busy", n, 640);
        check_cursor("ctrl_ff_cursor");
        check_screen("ctrl_ff_blank");

        // Random byte stream against the model
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 70)      ch = 7'($urandom_range(32, 126));
            else if (k < 82) ch = 7'h0A;
            else if (k < 87) ch = 7'h0D;
            else if (k < 93) ch = 7'h08;
            else if (k < 99) ch = 7'($urandom_range(0, 31));
            else             ch = 7'h0C;
            send_byte(ch);
            busy_count(n);
            check_cursor($sformatf("rand_%0d_cursor", i));
            if (i % 100 == 99) check_screen($sformatf("rand_%0d_screen", i));
        end

`ifdef LCD_TEXT_TERMINAL_CURSOR_BLINK_EN
        // Cursor cell shows the block for half of every 16-cycle period
        blk   = 0;
        other = 0;
        tif.column = 7'(mcc);
        tif.row    = 6'(mcr);
        @(negedge clock);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            if (tif.character === 7'h7F) blk++;
            else if (tif.character !== scr[mcr][mcc]) other++;
        end
        check("blink_block_samples", blk, 16);
        check("blink_other_samples", other, 0);
        blk = 0;
        tif.column = 7'((mcc + 1) % COLUMNS);
        tif.row    = 6'((mcr + 1) % ROWS);
        @(negedge clock);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            if (tif.character === 7'h7F) blk++;
        end
        check("blink_non_cursor_blocks", blk, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
